instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures a request, S2 holds the packed word.
// Optional IMM_RANGE_CHECK_EN also flags immediates that cannot be encoded losslessly.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [2:0]  FMT_I = 3'd0;
    localparam logic [2:0]  FMT_S = 3'd1;
    localparam logic [2:0]  FMT_B = 3'd2;
    localparam logic [2:0]  FMT_U = 3'd3;
    localparam logic [2:0]  FMT_J = 3'd4;
    localparam logic [2:0]  FMT_R = 3'd5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    req_t        req_q, req_d;
    logic        s1_valid_q, s1_valid_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        s2_free;
    logic [31:0] s1_imm;

    assign s1_imm  = req_q.imm;
    assign s2_free = !out_valid_q || out_ready;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        enc_instr = NOP_INSTR;
        enc_err   = 1'b0;
        case (req_q.fmt)
            FMT_I: begin
                enc_instr = {s1_imm[11:0], req_q.rs1, req_q.funct3, req_q.rd, req_q.opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = (s1_imm != {{20{s1_imm[11]}}, s1_imm[11:0]});
`endif
            end
            FMT_S: begin
                enc_instr = {s1_imm[11:5], req_q.rs2, req_q.rs1, req_q.funct3,
                             s1_imm[4:0], req_q.opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = (s1_imm != {{20{s1_imm[11]}}, s1_imm[11:0]});
`endif
            end
            FMT_B: begin
                enc_instr = {s1_imm[12], s1_imm[10:5], req_q.rs2, req_q.rs1, req_q.funct3,
                             s1_imm[4:1], s1_imm[11], req_q.opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = s1_imm[0] || (s1_imm != {{19{s1_imm[12]}}, s1_imm[12:0]});
`endif
            end
            FMT_U: begin
                enc_instr = {s1_imm[31:12], req_q.rd, req_q.opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = (s1_imm[11:0] != 12'd0);
`endif
            end
            FMT_J: begin
                enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             req_q.rd, req_q.opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = s1_imm[0] || (s1_imm != {{11{s1_imm[20]}}, s1_imm[20:0]});
`endif
            end
            FMT_R: begin
                enc_instr = {req_q.funct7, req_q.rs2, req_q.rs1, req_q.funct3,
                             req_q.rd, req_q.opcode};
            end
            default: begin
                enc_instr = NOP_INSTR;
                enc_err   = 1'b1;
            end
        endcase
    end

    always_comb begin
        // S1 may refill in the same cycle it drains into S2.
        in_ready    = !s1_valid_q || s2_free;
        s1_valid_d  = s1_valid_q;
        req_d       = req_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                req_d = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                          funct3: funct3, funct7: funct7, imm: imm};
            end
        end
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = enc_instr;
                err_d   = enc_err;
            end
        end
        if (out_valid_q && out_ready && err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: the S1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, backpressure, reset,
// saturation, and a randomized stream against an arithmetic reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_model = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        string       name;
        req_t        r;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[9];
    req_t        bp[4];
    logic [32:0] exp_q[$];

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%09h, required 0x%09h", name, act, exp);
        end
    endtask

    task automatic set_req(input req_t r);
        fmt = r.fmt; opcode = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
        funct3 = r.f3; funct7 = r.f7; imm = r.imm;
    endtask

    function automatic req_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im);
        req_t r;
        r.fmt = f; r.op = op; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.f3 = f3; r.f7 = f7; r.imm = im;
        return r;
    endfunction

    // Reference: bit fields placed with shifts and masks, range rules as signed integer bounds.
    function automatic logic [32:0] model(input req_t r);
        logic [31:0] w;
        logic [31:0] regs;
        logic        rng;
        int          s;
        s    = signed'(r.imm);
        regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
        rng  = 1'b0;
        case (r.fmt)
            3'd0: begin
                w   = ((r.imm & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
                      | (32'(r.rd) << 7) | 32'(r.op);
                rng = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                w   = (((r.imm >> 5) & 32'h7F) << 25) | regs | ((r.imm & 32'h1F) << 7) | 32'(r.op);
                rng = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w   = (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3F) << 25) | regs
                      | (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 32'h1) << 7) | 32'(r.op);
                rng = ((r.imm & 32'h1) != 0) || (s < -4096) || (s > 4095);
            end
            3'd3: begin
                w   = (r.imm & 32'hFFFF_F000) | (32'(r.rd) << 7) | 32'(r.op);
                rng = (r.imm & 32'hFFF) != 0;
            end
            3'd4: begin
                w   = (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21)
                      | (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hFF) << 12)
                      | (32'(r.rd) << 7) | 32'(r.op);
                rng = ((r.imm & 32'h1) != 0) || (s < -1048576) || (s > 1048575);
            end
            3'd5: w = (32'(r.f7) << 25) | regs | (32'(r.rd) << 7) | 32'(r.op);
            default: return {1'b1, 32'h0000_0013};
        endcase
        return {RC && rng, w};
    endfunction

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return $urandom & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
        endcase
    endfunction

    task automatic count_xfer(input logic ov, input logic oe);
        if (ov && out_ready && oe && cnt_model < 255) cnt_model++;
    endtask

    initial begin
        logic        rdy, ov, oe, have_held, prev_stall;
        logic [31:0] held, oi, prev_instr;
        logic [32:0] e;
        int          idx, got, sent;
        req_t        r;

        vecs[0] = '{"I_neg1", mk(0, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF0_0093, 1'b0};
        vecs[1] = '{"S_sw",   mk(1, 7'h23, 0, 3, 2, 2, 0, 32'd8),          32'h0021_A423, 1'b0};
        vecs[2] = '{"B_neg4", mk(2, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC), 32'hFE00_0EE3, 1'b0};
        vecs[3] = '{"J_800",  mk(4, 7'h6F, 1, 0, 0, 0, 0, 32'h0000_0800), 32'h0010_00EF, 1'b0};
        vecs[4] = '{"U_lui",  mk(3, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000), 32'h1234_52B7, 1'b0};
        vecs[5] = '{"R_sub",  mk(5, 7'h33, 1, 2, 3, 0, 7'h20, 32'hDEAD_BEEF), 32'h4031_00B3, 1'b0};
        vecs[6] = '{"I_800",  mk(0, 7'h13, 1, 0, 0, 0, 0, 32'h0000_0800), 32'h8000_0093, RC};
        vecs[7] = '{"fmt7",   mk(7, 7'h33, 9, 9, 9, 7, 7'h7F, 32'h1234_5678), 32'h0000_0013, 1'b1};
        vecs[8] = '{"fmt6",   mk(6, 7'h13, 1, 1, 1, 1, 1, 32'd1),          32'h0000_0013, 1'b1};
        for (int k = 0; k < 4; k++) bp[k] = mk(0, 7'h13, 5'(k + 1), 5'(k), 0, 0, 0, 32'(k * 7));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(vecs[0].r);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 33'(out_valid), 33'd0);
        check("rst_instr",     33'(instr),     33'd0);
        check("rst_err",       33'(err),       33'd0);
        check("rst_err_count", 33'(err_count), 33'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", 33'(in_ready), 33'd1);
        @(posedge clk); #1;

        // Directed vectors: one word each, latency and err_count tracked.
        for (int i = 0; i < 9; i++) begin
            set_req(vecs[i].r); in_valid = 1'b1; out_ready = 1'b1;
            #1 check({vecs[i].name, "_in_ready"}, 33'(in_ready), 33'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({vecs[i].name, "_not_early"}, 33'(out_valid), 33'd0);
            @(posedge clk); #1;
            check({vecs[i].name, "_word"}, {out_valid, instr}, {1'b1, vecs[i].exp_instr});
            check({vecs[i].name, "_err"}, 33'(err), 33'(vecs[i].exp_err));
            @(posedge clk); #1;
            if (vecs[i].exp_err && cnt_model < 255) cnt_model++;
            check({vecs[i].name, "_err_count"}, 33'(err_count), 33'(cnt_model));
        end

        // Backpressure: stall five cycles, then drain four words in order.
        out_ready = 1'b0; idx = 0; have_held = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) set_req(bp[idx]);
            #1 rdy = in_ready;
            if (out_valid) begin
                if (!have_held) begin
                    held = instr; have_held = 1'b1;
                    check("bp_first_word", 33'(held), 33'(model(bp[0]) & 33'h0FFFF_FFFF));
                end else begin
                    check("bp_hold", 33'(instr), 33'(held));
                end
            end
            @(posedge clk); #1;
            if (rdy && in_valid) idx++;
        end
        check("bp_accepts", 33'(idx), 33'd2);
        check("bp_in_ready_low", 33'(in_ready), 33'd0);
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) set_req(bp[idx]);
            #1 rdy = in_ready;
            if (out_valid) begin
                check("bp_order", {err, instr}, model(bp[got]));
                got++;
            end
            @(posedge clk); #1;
            if (rdy && in_valid) idx++;
        end
        in_valid = 1'b0;
        check("bp_drained", 33'(got), 33'd4);

        // Reset with both stages full: everything in flight is discarded.
        out_ready = 1'b0;
        set_req(vecs[7].r);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("full_before_rst", {in_ready, out_valid}, 33'b01);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1; cnt_model = 0;
        check("midrst_out_valid", 33'(out_valid), 33'd0);
        check("midrst_err_count", 33'(err_count), 33'd0);
        check("midrst_in_ready",  33'(in_ready),  33'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("midrst_no_ghost", 33'(out_valid), 33'd0);
        end

        // Saturation: 300 erroring transfers.
        set_req(vecs[7].r); sent = 0;
        for (int c = 0; c < 400 && sent < 300; c++) begin
            in_valid = 1'b1;
            #1 rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) sent++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && out_valid; c++) begin
            @(posedge clk); #1;
        end
        check("sat_sent", 33'(sent), 33'd300);
        check("sat_err_count", 33'(err_count), 33'd255);

        // Randomized stream against the reference model and scoreboard.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cnt_model = 0; prev_stall = 1'b0; prev_instr = '0;
        for (int c = 0; c < 1500; c++) begin
            r = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
            in_valid  = (c < 1480) && ($urandom_range(0, 9) < 7);
            out_ready = (c >= 1480) || ($urandom_range(0, 3) != 0);
            set_req(r);
            #1;
            rdy = in_ready; ov = out_valid; oi = instr; oe = err;
            if (prev_stall) check("rnd_hold", {ov, oi}, {1'b1, prev_instr});
            if (ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rnd_extra: got word 0x%08h, required none", oi);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_word", {oe, oi}, e);
                end
            end
            @(posedge clk); #1;
            if (rdy && in_valid) exp_q.push_back(model(r));
            count_xfer(ov, oe);
            check("rnd_err_count", 33'(err_count), 33'(cnt_model));
            prev_stall = ov && !out_ready;
            prev_instr = oi;
        end
        check("rnd_all_emitted", 33'(exp_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
